// File: rtl/contador_cascada.sv
// -----------------------------------------------------------------------------
// contador_cascada
// Extends a 4-bit mode counter (up / down / down-by-3 / load) with an upper
// field ALTO, giving a wide count {ALTO, Q_IN}. ALTO steps once per rising
// edge of the upstream RCO, in the direction selected by MODO. Sticky flags
// record wrap-around and dropped snapshot requests. A valid/ready port hands
// {ALTO, Q_IN} snapshots to a downstream reader.
//
// Optional feature: define CONTADOR_CASCADA_COMPARE_EN to add the UMBRAL
// input and the COINCIDE output, a registered single-cycle pulse raised when
// {ALTO, Q_IN} starts to equal UMBRAL.
// -----------------------------------------------------------------------------
module contador_cascada #(
    parameter int BITS_ALTOS = 8
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    ENB,
    input  logic [1:0]              MODO,
    input  logic [3:0]              Q_IN,
    input  logic                    RCO_IN,
    input  logic                    CLR,
    input  logic                    SNAP_REQ,
    input  logic                    READY,
`ifdef CONTADOR_CASCADA_COMPARE_EN
    input  logic [BITS_ALTOS+3:0]   UMBRAL,
    output logic                    COINCIDE,
`endif
    output logic [BITS_ALTOS-1:0]   ALTO,
    output logic                    VALID,
    output logic [BITS_ALTOS+3:0]   SNAP,
    output logic                    OVF,
    output logic                    UNF,
    output logic                    MISSED
);

    localparam logic [BITS_ALTOS-1:0] ALTO_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } estado_t;

    estado_t estado;
    estado_t estado_sig;

    logic rco_prev;
    logic evento;
    logic capturar;
    logic perdido;

    // One event per rising edge of RCO; a long-high RCO counts only once.
    always_comb begin
        evento = RCO_IN & ~rco_prev & ENB;
    end

    // Remember last RCO every cycle, independent of ENB.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours, exactly like the hardware.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rco_prev <= 1'b0;
        end else begin
            rco_prev <= RCO_IN;
        end
    end

    // Upper count field and sticky flags; CLR wins over any event.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ALTO   <= '0;
            OVF    <= 1'b0;
            UNF    <= 1'b0;
            MISSED <= 1'b0;
        end else if (CLR) begin
            ALTO   <= '0;
            OVF    <= 1'b0;
            UNF    <= 1'b0;
            MISSED <= 1'b0;
        end else begin
            if (perdido) begin
                MISSED <= 1'b1;
            end
            if (evento) begin
                case (MODO)
                    2'b00: begin
                        ALTO <= ALTO + 1'b1;
                        if (ALTO == ALTO_MAX) begin
                            OVF <= 1'b1;
                        end
                    end
                    2'b01, 2'b10: begin
                        ALTO <= ALTO - 1'b1;
                        if (ALTO == '0) begin
                            UNF <= 1'b1;
                        end
                    end
                    default: begin
                        // Parallel load upstream: upper field holds.
                    end
                endcase
            end
        end
    end

    // Snapshot FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Snapshot FSM next state, capture strobe and drop detection.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        estado_sig = estado;
        capturar   = 1'b0;
        perdido    = 1'b0;
        case (estado)
            IDLE: begin
                if (SNAP_REQ) begin
                    capturar   = 1'b1;
                    estado_sig = HOLD;
                end
            end
            HOLD: begin
                if (READY) begin
                    if (SNAP_REQ) begin
                        capturar = 1'b1;
                    end else begin
                        estado_sig = IDLE;
                    end
                end else if (SNAP_REQ) begin
                    perdido = 1'b1;
                end
            end
            default: begin
                estado_sig = IDLE;
            end
        endcase
    end

    // VALID comes straight from the state so an async reset drops it at once.
    always_comb begin
        VALID = (estado == HOLD);
    end

    // Snapshot data register; only written on an accepted request.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            SNAP <= '0;
        end else if (capturar) begin
            SNAP <= {ALTO, Q_IN};
        end
    end

`ifdef CONTADOR_CASCADA_COMPARE_EN
    logic igual;
    logic igual_prev;

    // Equality of the wide count against the threshold.
    always_comb begin
        igual = ({ALTO, Q_IN} == UMBRAL);
    end

    // Pulse on the first cycle of equality; CLR suppresses the pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            igual_prev <= 1'b0;
            COINCIDE   <= 1'b0;
        end else begin
            igual_prev <= igual;
            COINCIDE   <= igual & ~igual_prev & ~CLR;
        end
    end
`endif

endmodule

// File: tb/tb_contador_cascada.sv
// -----------------------------------------------------------------------------
// Testbench for contador_cascada (BITS_ALTOS = 8).
// A behavioural model (integer arithmetic modulo 256) tracks the expected
// outputs; directed scenarios also compare against literal values.
// Define CONTADOR_CASCADA_COMPARE_EN to exercise the compare feature.
// -----------------------------------------------------------------------------
module tb_contador_cascada;

    localparam int BA   = 8;
    localparam int MAXA = (1 << BA) - 1;

    logic            CLK;
    logic            RESET_N;
    logic            ENB;
    logic [1:0]      MODO;
    logic [3:0]      Q_IN;
    logic            RCO_IN;
    logic            CLR;
    logic            SNAP_REQ;
    logic            READY;
    logic [BA-1:0]   ALTO;
    logic            VALID;
    logic [BA+3:0]   SNAP;
    logic            OVF;
    logic            UNF;
    logic            MISSED;
`ifdef CONTADOR_CASCADA_COMPARE_EN
    logic [BA+3:0]   UMBRAL;
    logic            COINCIDE;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_alto;
    int m_snap;
    bit m_valid, m_ovf, m_unf, m_miss, m_rco_prev;
    bit m_eq_prev, m_coin;

    contador_cascada #(.BITS_ALTOS(BA)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .ENB      (ENB),
        .MODO     (MODO),
        .Q_IN     (Q_IN),
        .RCO_IN   (RCO_IN),
        .CLR      (CLR),
        .SNAP_REQ (SNAP_REQ),
        .READY    (READY),
`ifdef CONTADOR_CASCADA_COMPARE_EN
        .UMBRAL   (UMBRAL),
        .COINCIDE (COINCIDE),
`endif
        .ALTO     (ALTO),
        .VALID    (VALID),
        .SNAP     (SNAP),
        .OVF      (OVF),
        .UNF      (UNF),
        .MISSED   (MISSED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_alto = 0; m_snap = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
        m_miss = 0; m_rco_prev = 0; m_eq_prev = 0; m_coin = 0;
    endtask

    // Advance one clock and apply the behavioural rules to the model using
    // the inputs present at that edge; returns 1 ns after the edge.
    task automatic tick();
        bit ev;
`ifdef CONTADOR_CASCADA_COMPARE_EN
        bit eq;
`endif
        @(posedge CLK);
        ev = RCO_IN && !m_rco_prev && ENB;
        m_rco_prev = RCO_IN;
`ifdef CONTADOR_CASCADA_COMPARE_EN
        eq = ((m_alto * 16 + int'(Q_IN)) == int'(UMBRAL));
        m_coin = !CLR && eq && !m_eq_prev;
        m_eq_prev = eq;
`endif
        if (!m_valid) begin
            if (SNAP_REQ) begin
                m_snap = m_alto * 16 + int'(Q_IN);
                m_valid = 1;
            end
        end else if (READY) begin
            if (SNAP_REQ) m_snap = m_alto * 16 + int'(Q_IN);
            else          m_valid = 0;
        end else if (SNAP_REQ) begin
            m_miss = 1;
        end
        if (CLR) begin
            m_alto = 0; m_ovf = 0; m_unf = 0; m_miss = 0;
        end else if (ev) begin
            if (MODO == 2'b00) begin
                if (m_alto == MAXA) m_ovf = 1;
                m_alto = (m_alto + 1) % (MAXA + 1);
            end else if (MODO != 2'b11) begin
                if (m_alto == 0) m_unf = 1;
                m_alto = (m_alto + MAXA) % (MAXA + 1);
            end
        end
        #1;
    endtask

    // n isolated RCO rises with current ENB/MODO.
    task automatic pulse_events(input int n);
        for (int i = 0; i < n; i++) begin
            RCO_IN = 1'b1; tick();
            RCO_IN = 1'b0; tick();
        end
    endtask

    task automatic do_clr();
        CLR = 1'b1; tick(); CLR = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({ALTO, VALID, SNAP, OVF, UNF, MISSED} !== '0) begin
            errors++;
            $display("FAIL reset_initial: alto=%h valid=%b snap=%h ovf=%b unf=%b missed=%b, all zero required",
                     ALTO, VALID, SNAP, OVF, UNF, MISSED);
        end
        ENB = 1'b1; MODO = 2'b00;
        pulse_events(18);
        Q_IN = 4'h9; SNAP_REQ = 1'b1; tick(); SNAP_REQ = 1'b0;
        checks++;
        if (ALTO !== 8'h12 || VALID !== 1'b1 || SNAP !== 12'h129) begin
            errors++;
            $display("FAIL reset_setup: alto=%h valid=%b snap=%h, required 12 1 129", ALTO, VALID, SNAP);
        end
        #3 RESET_N = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ALTO, VALID, SNAP, OVF, UNF, MISSED} !== '0) begin
            errors++;
            $display("FAIL reset_async: alto=%h valid=%b snap=%h ovf=%b unf=%b missed=%b, all zero required",
                     ALTO, VALID, SNAP, OVF, UNF, MISSED);
        end
        #1 RESET_N = 1'b1;
        tick();
        checks++;
        if (ALTO !== 8'h00 || VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: alto=%h valid=%b, required 00 0", ALTO, VALID);
        end
    endtask

    task automatic test_up_wrap();
        do_clr();
        ENB = 1'b1; MODO = 2'b00;
        for (int i = 0; i < 40; i++) begin
            Q_IN   = 4'(i % 16);
            RCO_IN = (i > 0) && ((i - 1) % 16 == 15);
            tick();
        end
        checks++;
        if (ALTO !== 8'h02) begin
            errors++;
            $display("FAIL up_wrap_alto: got %h required 02", ALTO);
        end
        // Load of F held: RCO stays high after the first cycle.
        MODO = 2'b11; Q_IN = 4'hF; RCO_IN = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            RCO_IN = 1'b1; tick();
        end
        checks++;
        if (ALTO !== 8'h02) begin
            errors++;
            $display("FAIL up_hold_load: got %h required 02", ALTO);
        end
        // RCO held high in up mode counts exactly once.
        RCO_IN = 1'b0; MODO = 2'b00; tick();
        for (int i = 0; i < 10; i++) begin
            RCO_IN = 1'b1; tick();
        end
        checks++;
        if (ALTO !== 8'h03) begin
            errors++;
            $display("FAIL up_long_rco: got %h required 03", ALTO);
        end
        // Rise while ENB low is ignored; rco_prev still tracks it.
        RCO_IN = 1'b0; tick();
        ENB = 1'b0; RCO_IN = 1'b1; tick();
        ENB = 1'b1; tick(); tick();
        RCO_IN = 1'b0; tick();
        checks++;
        if (ALTO !== 8'h03) begin
            errors++;
            $display("FAIL enb_gating: got %h required 03", ALTO);
        end
    endtask

    task automatic test_ovf_unf();
        do_clr();
        ENB = 1'b1; MODO = 2'b00;
        pulse_events(255);
        checks++;
        if (ALTO !== 8'hFF || OVF !== 1'b0) begin
            errors++;
            $display("FAIL preload_ff: alto=%h ovf=%b, required ff 0", ALTO, OVF);
        end
        pulse_events(1);
        checks++;
        if (ALTO !== 8'h00 || OVF !== 1'b1) begin
            errors++;
            $display("FAIL overflow: alto=%h ovf=%b, required 00 1", ALTO, OVF);
        end
        do_clr();
        checks++;
        if (OVF !== 1'b0) begin
            errors++;
            $display("FAIL clr_ovf: ovf=%b required 0", OVF);
        end
        MODO = 2'b01;
        pulse_events(1);
        checks++;
        if (ALTO !== 8'hFF || UNF !== 1'b1) begin
            errors++;
            $display("FAIL underflow_01: alto=%h unf=%b, required ff 1", ALTO, UNF);
        end
        do_clr();
        MODO = 2'b10;
        pulse_events(1);
        checks++;
        if (ALTO !== 8'hFF || UNF !== 1'b1) begin
            errors++;
            $display("FAIL underflow_10: alto=%h unf=%b, required ff 1", ALTO, UNF);
        end
        MODO = 2'b00; RCO_IN = 1'b1; CLR = 1'b1; tick();
        CLR = 1'b0; RCO_IN = 1'b0; tick();
        checks++;
        if (ALTO !== 8'h00 || UNF !== 1'b0) begin
            errors++;
            $display("FAIL clr_vs_event: alto=%h unf=%b, required 00 0", ALTO, UNF);
        end
    endtask

    task automatic test_snapshot();
        do_clr();
        ENB = 1'b1; MODO = 2'b00;
        pulse_events(3);
        Q_IN = 4'h7; SNAP_REQ = 1'b1; READY = 1'b0; tick(); SNAP_REQ = 1'b0;
        checks++;
        if (VALID !== 1'b1 || SNAP !== 12'h037) begin
            errors++;
            $display("FAIL snap_capture: valid=%b snap=%h, required 1 037", VALID, SNAP);
        end
        for (int i = 0; i < 5; i++) begin
            Q_IN = 4'($urandom);
            tick();
            checks++;
            if (VALID !== 1'b1 || SNAP !== 12'h037) begin
                errors++;
                $display("FAIL snap_stable[%0d]: valid=%b snap=%h, required 1 037", i, VALID, SNAP);
            end
        end
        READY = 1'b1; tick(); READY = 1'b0;
        checks++;
        if (VALID !== 1'b0) begin
            errors++;
            $display("FAIL snap_release: valid=%b required 0", VALID);
        end
    endtask

    task automatic test_back_to_back();
        pulse_events(1);
        Q_IN = 4'h5; SNAP_REQ = 1'b1; READY = 1'b0; tick();
        checks++;
        if (VALID !== 1'b1 || SNAP !== 12'h045 || MISSED !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: valid=%b snap=%h missed=%b, required 1 045 0", VALID, SNAP, MISSED);
        end
        Q_IN = 4'hA; tick();
        checks++;
        if (MISSED !== 1'b1 || SNAP !== 12'h045) begin
            errors++;
            $display("FAIL b2b_drop: missed=%b snap=%h, required 1 045", MISSED, SNAP);
        end
        Q_IN = 4'h2; READY = 1'b1; tick();
        checks++;
        if (VALID !== 1'b1 || SNAP !== 12'h042) begin
            errors++;
            $display("FAIL b2b_accept: valid=%b snap=%h, required 1 042", VALID, SNAP);
        end
        SNAP_REQ = 1'b0; READY = 1'b0;
        do_clr();
        checks++;
        if (MISSED !== 1'b0 || VALID !== 1'b1 || SNAP !== 12'h042) begin
            errors++;
            $display("FAIL clr_keeps_snap: missed=%b valid=%b snap=%h, required 0 1 042", MISSED, VALID, SNAP);
        end
        READY = 1'b1; tick(); READY = 1'b0;
        checks++;
        if (VALID !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release: valid=%b required 0", VALID);
        end
    endtask

`ifdef CONTADOR_CASCADA_COMPARE_EN
    task automatic test_compare();
        UMBRAL = 12'h010;
        do_clr();
        ENB = 1'b1; MODO = 2'b00; Q_IN = 4'h3;
        pulse_events(1);
        Q_IN = 4'hF; tick();
        for (int i = 0; i < 4; i++) begin
            Q_IN = 4'h0; tick();
            checks++;
            if (COINCIDE !== (i == 0)) begin
                errors++;
                $display("FAIL compare_pulse[%0d]: coincide=%b required %b", i, COINCIDE, (i == 0));
            end
        end
        UMBRAL = 12'h003;
    endtask
`endif

    task automatic test_random();
        logic [BA-1:0] exp_alto;
        logic [BA+3:0] exp_snap;
        for (int i = 0; i < 400; i++) begin
            ENB      = ($urandom_range(0, 3) != 0);
            MODO     = 2'($urandom);
            Q_IN     = 4'($urandom);
            RCO_IN   = 1'($urandom);
            CLR      = ($urandom_range(0, 31) == 0);
            SNAP_REQ = ($urandom_range(0, 2) == 0);
            READY    = 1'($urandom);
            tick();
            exp_alto = BA'(m_alto);
            exp_snap = (BA + 4)'(m_snap);
            checks++;
            if (ALTO !== exp_alto || VALID !== m_valid || SNAP !== exp_snap ||
                OVF !== m_ovf || UNF !== m_unf || MISSED !== m_miss) begin
                errors++;
                $display("FAIL random[%0d]: got alto=%h valid=%b snap=%h ovf=%b unf=%b missed=%b; required %h %b %h %b %b %b",
                         i, ALTO, VALID, SNAP, OVF, UNF, MISSED,
                         exp_alto, m_valid, exp_snap, m_ovf, m_unf, m_miss);
            end
`ifdef CONTADOR_CASCADA_COMPARE_EN
            checks++;
            if (COINCIDE !== m_coin) begin
                errors++;
                $display("FAIL random_coincide[%0d]: got %b required %b", i, COINCIDE, m_coin);
            end
`endif
        end
        CLR = 1'b0; SNAP_REQ = 1'b0; READY = 1'b0; RCO_IN = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; ENB = 1'b0; MODO = 2'b00; Q_IN = 4'h0; RCO_IN = 1'b0;
        CLR = 1'b0; SNAP_REQ = 1'b0; READY = 1'b0;
`ifdef CONTADOR_CASCADA_COMPARE_EN
        UMBRAL = 12'h003;
`endif
        model_reset();
        #12 RESET_N = 1'b1;
        tick();
        test_reset();
        test_up_wrap();
        test_ovf_unf();
        test_snapshot();
        test_back_to_back();
`ifdef CONTADOR_CASCADA_COMPARE_EN
        test_compare();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_cascada.md
Name: contador_cascada

Overview:
- Sits directly downstream of the 4-bit mode counter (up / down / down-by-3 / parallel load).
- Consumes the counter's Q, RCO and MODO and extends the count with an upper field of BITS_ALTOS bits, forming a wide count {ALTO, Q}.
- Provides sticky overflow/underflow flags and a valid/ready snapshot port for a downstream reader.

Parameters:
- BITS_ALTOS, 8, width of the upper count field; total snapshot width = BITS_ALTOS+4.

Ports:
- CLK  input  1  single clock; all registers on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- ENB  input  1  same enable that drives the upstream counter; no event counted when low.
- MODO  input  2  same mode bus that drives the upstream counter.
- Q_IN  input  4  upstream counter Q.
- RCO_IN  input  1  upstream counter RCO (registered, high while the previous Q was 4'hF).
- CLR  input  1  synchronous clear of ALTO and flags.
- SNAP_REQ  input  1  single-cycle snapshot request.
- READY  input  1  downstream accepts snapshot.
- ALTO  output  BITS_ALTOS  upper count field.
- VALID  output  1  snapshot held and valid.
- SNAP  output  BITS_ALTOS+4  captured {ALTO, Q_IN}.
- OVF  output  1  sticky: ALTO wrapped max->0.
- UNF  output  1  sticky: ALTO wrapped 0->max.
- MISSED  output  1  sticky: SNAP_REQ dropped.

Behaviour:
- Reset (RESET_N=0, asynchronous): ALTO=0, SNAP=0, VALID=0, OVF=0, UNF=0, MISSED=0, rco_prev=0, FSM=IDLE. Deassertion takes effect at the next CLK edge.
- Event detect: evento = RCO_IN & ~rco_prev & ENB.
  - rco_prev <= RCO_IN every cycle, regardless of ENB.
  - RCO held high across many cycles (Q parked at F, or repeated load of F) counts exactly once.
- ALTO update on evento, selected by MODO:
  - 00: ALTO+1 mod 2^BITS_ALTOS; OVF<=1 if ALTO was all-ones.
  - 01 or 10: ALTO-1 mod 2^BITS_ALTOS; UNF<=1 if ALTO was 0.
  - 11 (parallel load): no change.
- Update latency: ALTO changes on the edge after the cycle in which RCO_IN rises.
- CLR priority over evento in the same cycle. CLR zeroes ALTO, OVF, UNF and MISSED. It does not touch VALID or SNAP.
- Snapshot FSM, two states:
  - IDLE: VALID=0. SNAP_REQ=1 -> SNAP <= {ALTO, Q_IN} (register values before this edge's ALTO update); go to HOLD. VALID rises one cycle after SNAP_REQ.
  - HOLD: VALID=1; SNAP stable until handshake.
    - READY=1 & SNAP_REQ=0 -> IDLE.
    - READY=1 & SNAP_REQ=1 -> capture new SNAP, stay HOLD (back-to-back, no bubble).
    - READY=0 & SNAP_REQ=1 -> request dropped, MISSED<=1, SNAP unchanged.
  - READY in IDLE: ignored.
- Reset mid-HOLD: VALID drops immediately (asynchronous); snapshot lost.
- All arithmetic is unsigned and modular. No saturation.

Optional Feature:
- Macro CONTADOR_CASCADA_COMPARE_EN.
- Defined:
  - Adds input UMBRAL [BITS_ALTOS+3:0] and output COINCIDE (1 bit).
  - COINCIDE is registered: one-cycle pulse on the edge after {ALTO, Q_IN} first equals UMBRAL (rising-edge of equality). Reset value 0.
  - CLR forces COINCIDE=0 that cycle.
- Undefined: UMBRAL and COINCIDE ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: RESET_N=0 mid-cycle with VALID=1, ALTO=8'h12 -> all outputs 0 immediately. After release, ALTO=0 and FSM=IDLE.
- Up wrap: MODO=00, ENB=1, counter runs 40 cycles from Q=0 -> ALTO=2 after the 2nd RCO rise. Hold Q at F via MODO=11, D=F for 10 cycles -> ALTO still 2.
- Overflow/underflow: with BITS_ALTOS=8, preload ALTO=8'hFF via events, then one more up event -> ALTO=0, OVF=1. CLR -> OVF=0. MODO=01 event at ALTO=0 -> ALTO=8'hFF, UNF=1. CLR and evento in the same cycle -> ALTO=0.
- Snapshot: ALTO=3, Q_IN=4'h7, SNAP_REQ pulse -> next cycle VALID=1, SNAP=12'h037. READY held 0 for 5 cycles -> SNAP stable. READY=1 -> VALID=0 next cycle.
- Back-to-back/drop: in HOLD, SNAP_REQ with READY=0 -> MISSED=1, SNAP unchanged. SNAP_REQ with READY=1 (ALTO=4, Q=2) -> VALID stays 1, SNAP=12'h042.
- Compare (macro defined): UMBRAL=12'h010, counting up from 0 -> COINCIDE high exactly one cycle after Q_IN=0 with ALTO=1. No pulse while value is held at 12'h010.
